// File: rtl/sha_mem_pkg.sv
// Shared types, default widths and the burst-length clamp for the SHA memory-port arbiter.
package sha_mem_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   localparam int DEF_MAX_BURST = 16;
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_DATA_W    = 32;
   localparam int LEN_W         = 5;

   // A zero-length request still moves one word; anything longer is cut to max_burst.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                  input int max_burst);
      logic [31:0] len32;
      len32 = {{(32-LEN_W){1'b0}}, len};
      if (len == '0) return LEN_W'(1);
      if (len32 > 32'(max_burst)) return LEN_W'(max_burst);
      return len;
   endfunction

endpackage

// File: rtl/sha_mem_arbiter_if.sv
// Requester-side burst bus, tagged read-return bus and the shared memory port.
interface sha_mem_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int ID_W    = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_we;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*5-1:0]      req_len;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        wr_ack;
   logic [NUM_REQ-1:0]        done;
   logic                      rd_valid;
   logic [ID_W-1:0]           rd_id;
   logic                      rd_last;
   logic [DATA_W-1:0]         rd_data;
   logic                      mem_we;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_write_data;
   logic [DATA_W-1:0]         mem_read_data;

   modport master (
      output req, req_we, req_addr, req_len, req_wdata, mem_read_data,
      input  gnt, wr_ack, done, rd_valid, rd_id, rd_last, rd_data,
      input  mem_we, mem_addr, mem_write_data
   );

   modport slave (
      input  req, req_we, req_addr, req_len, req_wdata, mem_read_data,
      output gnt, wr_ack, done, rd_valid, rd_id, rd_last, rd_data,
      output mem_we, mem_addr, mem_write_data
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx,
   output logic               any
);
   int cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (int'(ptr) + i) % NUM_REQ;
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = ID_W'(cand);
         end
      end
   end
endmodule

// File: rtl/sha_mem_arbiter.sv
// Round-robin arbiter granting atomic read/write bursts on one synchronous memory port;
// read data comes back one cycle later on a shared bus tagged with the owner id.
module sha_mem_arbiter
   import sha_mem_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W
) (
   input logic              clk,
   input logic              reset_n,
   sha_mem_arbiter_if.slave bus
);
   localparam int ID_W = $clog2(NUM_REQ);

   state_e             state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [NUM_REQ-1:0] own_q, own_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic               we_q, we_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   beat_q, beat_d;
   logic               rd_valid_q, rd_valid_d;
   logic               rd_last_q, rd_last_d;
   logic [ID_W-1:0]    rd_id_q, rd_id_d;
   logic [NUM_REQ-1:0] done_q, done_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [ID_W-1:0]    pick_idx;
   logic               pick_any;
   logic               last_beat;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req (bus.req),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign last_beat = (state_q == BURST) && (beat_q == len_q - LEN_W'(1));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      own_d   = own_q;
      base_d  = base_q;
      we_d    = we_q;
      len_d   = len_q;
      beat_d  = beat_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               id_d    = pick_idx;
               own_d   = pick_gnt;
               base_d  = bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
               we_d    = bus.req_we[pick_idx];
               len_d   = clamp_len(bus.req_len[int'(pick_idx)*LEN_W +: LEN_W], MAX_BURST);
               beat_d  = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            beat_d = beat_q + LEN_W'(1);
            if (last_beat) begin
               ptr_d   = (int'(id_q) == NUM_REQ - 1) ? '0 : id_q + ID_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Read beats return one cycle after their address; done lines up with that slot.
      rd_valid_d = (state_q == BURST) && !we_q;
      rd_last_d  = rd_valid_d && last_beat;
      rd_id_d    = rd_valid_d ? id_q : rd_id_q;
      done_d     = last_beat ? own_q : '0;
   end

   always_comb begin
      bus.gnt            = '0;
      bus.wr_ack         = '0;
      bus.mem_we         = 1'b0;
      bus.mem_addr       = '0;
      bus.mem_write_data = '0;
      if (state_q == BURST) begin
         bus.gnt            = own_q;
         bus.wr_ack         = we_q ? own_q : '0;
         bus.mem_we         = we_q;
         bus.mem_addr       = base_q + ADDR_W'(beat_q);
         bus.mem_write_data = bus.req_wdata[int'(id_q)*DATA_W +: DATA_W];
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_last  = rd_last_q;
   assign bus.rd_id    = rd_id_q;
   assign bus.rd_data  = bus.mem_read_data;
   assign bus.done     = done_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         beat_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_id_q    <= '0;
         done_q     <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         beat_q     <= beat_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         rd_id_q    <= rd_id_d;
         done_q     <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      id_q   <= id_d;
      own_q  <= own_d;
      base_q <= base_d;
      we_q   <= we_d;
      len_q  <= len_d;
   end
endmodule
